psa_share_arb: RTL and testbench

- Shares one 16-bit parallel saturating adder (four independent signed 4-bit lanes) between two requesters, e.g. the EX-stage PSA path and a debug/test port.
- Provides round-robin arbitration, operand capture, a registered result with a response handshake, and per-requester overflow statistics.
- Sits beside the ALU. The adder datapath is instantiated internally; requesters never drive it directly.

---
 rtl/psa_share_arb.sv | 162 ++++++++++++++++
 tb/tb_psa_share_arb.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/psa_share_arb.sv
// Shares one four-lane signed 4-bit saturating adder between two requesters
// with round-robin arbitration, a registered response handshake and overflow counters.

module psa_sat_add16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] sum,
    output logic        err
);

    logic [3:0] lane_ovf;

    // Each nibble is an independent signed lane; overflow shows up as a sign flip
    // when both operands share a sign.
    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic [3:0] an;
        logic [3:0] bn;
        logic [3:0] wrap;
        logic       pos_ovf;
        logic       neg_ovf;

        assign an      = a[4*l +: 4];
        assign bn      = b[4*l +: 4];
        assign wrap    = an + bn;
        assign pos_ovf = ~an[3] & ~bn[3] &  wrap[3];
        assign neg_ovf =  an[3] &  bn[3] & ~wrap[3];
        assign sum[4*l +: 4] = pos_ovf ? 4'h7 : (neg_ovf ? 4'h8 : wrap);
        assign lane_ovf[l]   = pos_ovf | neg_ovf;
    end

    assign err = |lane_ovf;

endmodule

module psa_share_arb #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req,
    input  logic [15:0]      A0,
    input  logic [15:0]      B0,
    input  logic [15:0]      A1,
    input  logic [15:0]      B1,
    output logic [1:0]       gnt,
    output logic [1:0]       rsp_vld,
    input  logic [1:0]       rsp_rdy,
    output logic [15:0]      rsp_sum,
    output logic             rsp_err,
    output logic             busy,
    output logic [CNT_W-1:0] ovf_cnt0,
    output logic [CNT_W-1:0] ovf_cnt1,
    input  logic [1:0]       cnt_clr
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t      state;
    logic        prio;
    logic        owner;
    logic        winner;
    logic        accept;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [15:0] add_sum;
    logic        add_err;

    psa_sat_add16 u_add (
        .a   (op_a),
        .b   (op_b),
        .sum (add_sum),
        .err (add_err)
    );

    // prio names the requester favoured on a tie; it flips to the other side
    // each time a response is accepted, so the last-served requester yields.
    always_comb begin
        winner = prio;
        if (req == 2'b01) begin
            winner = 1'b0;
        end else if (req == 2'b10) begin
            winner = 1'b1;
        end
    end

    assign accept = (state == RESP) && rsp_rdy[owner];
    assign busy   = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            prio    <= 1'b0;
            owner   <= 1'b0;
            op_a    <= '0;
            op_b    <= '0;
            gnt     <= '0;
            rsp_vld <= '0;
            rsp_sum <= '0;
            rsp_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        op_a  <= winner ? A1 : A0;
                        op_b  <= winner ? B1 : B0;
                        owner <= winner;
                        gnt   <= winner ? 2'b10 : 2'b01;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    gnt     <= '0;
                    rsp_sum <= add_sum;
                    rsp_err <= add_err;
                    rsp_vld <= owner ? 2'b10 : 2'b01;
                    state   <= RESP;
                end
                RESP: begin
                    if (rsp_rdy[owner]) begin
                        rsp_vld <= '0;
                        prio    <= ~owner;
                        state   <= IDLE;
                    end
                end
                default: begin
                    gnt     <= '0;
                    rsp_vld <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // A clear request takes precedence over a simultaneous increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt0 <= '0;
        end else if (cnt_clr[0]) begin
            ovf_cnt0 <= '0;
        end else if (accept && !owner && rsp_err && ovf_cnt0 != CNT_MAX) begin
            ovf_cnt0 <= ovf_cnt0 + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt1 <= '0;
        end else if (cnt_clr[1]) begin
            ovf_cnt1 <= '0;
        end else if (accept && owner && rsp_err && ovf_cnt1 != CNT_MAX) begin
            ovf_cnt1 <= ovf_cnt1 + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_psa_share_arb.sv
// Testbench for psa_share_arb: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model of the shared adder.

module tb_psa_share_arb;

    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       req = '0;
    logic [15:0]      a0 = '0;
    logic [15:0]      b0 = '0;
    logic [15:0]      a1 = '0;
    logic [15:0]      b1 = '0;
    logic [1:0]       rsp_rdy = '0;
    logic [1:0]       cnt_clr = '0;
    logic [1:0]       gnt;
    logic [1:0]       rsp_vld;
    logic [15:0]      rsp_sum;
    logic             rsp_err;
    logic             busy;
    logic [CNT_W-1:0] ovf_cnt0;
    logic [CNT_W-1:0] ovf_cnt1;

    psa_share_arb #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .A0       (a0),
        .B0       (b0),
        .A1       (a1),
        .B1       (b1),
        .gnt      (gnt),
        .rsp_vld  (rsp_vld),
        .rsp_rdy  (rsp_rdy),
        .rsp_sum  (rsp_sum),
        .rsp_err  (rsp_err),
        .busy     (busy),
        .ovf_cnt0 (ovf_cnt0),
        .ovf_cnt1 (ovf_cnt1),
        .cnt_clr  (cnt_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model view: phase 0 = waiting, 1 = grant cycle, 2 = result offered.
    int          m_phase = 0;
    int          m_owner = 0;
    int          m_prio = 0;
    logic [15:0] m_op_a = '0;
    logic [15:0] m_op_b = '0;
    logic [15:0] m_sum = '0;
    int          m_err = 0;
    int          m_cnt [2] = '{0, 0};

    function automatic logic [16:0] refAdd(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] s;
        logic        e;
        int          x;
        int          y;
        int          t;
        s = '0;
        e = 1'b0;
        for (int l = 0; l < 4; l++) begin
            x = int'(a[4*l +: 4]);
            y = int'(b[4*l +: 4]);
            if (x > 7) x = x - 16;
            if (y > 7) y = y - 16;
            t = x + y;
            if (t > 7) begin
                t = 7;
                e = 1'b1;
            end else if (t < -8) begin
                t = -8;
                e = 1'b1;
            end
            s[4*l +: 4] = 4'(t);
        end
        return {e, s};
    endfunction

    task automatic modelStep();
        logic [16:0] r;
        int          cmax;
        cmax = (1 << CNT_W) - 1;
        if (!rst_n) begin
            m_phase = 0; m_owner = 0; m_prio = 0;
            m_op_a = '0; m_op_b = '0; m_sum = '0; m_err = 0;
            m_cnt[0] = 0; m_cnt[1] = 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (cnt_clr[i]) m_cnt[i] = 0;
                else if (m_phase == 2 && rsp_rdy[m_owner] && m_owner == i && m_err == 1 && m_cnt[i] < cmax)
                    m_cnt[i] = m_cnt[i] + 1;
            end
            case (m_phase)
                0: if (req != 2'b00) begin
                    m_owner = (req == 2'b11) ? m_prio : (req[1] ? 1 : 0);
                    m_op_a  = (m_owner == 1) ? a1 : a0;
                    m_op_b  = (m_owner == 1) ? b1 : b0;
                    m_phase = 1;
                end
                1: begin
                    r       = refAdd(m_op_a, m_op_b);
                    m_sum   = r[15:0];
                    m_err   = int'(r[16]);
                    m_phase = 2;
                end
                default: if (rsp_rdy[m_owner]) begin
                    m_prio  = 1 - m_owner;
                    m_phase = 0;
                end
            endcase
        end
    endtask

    task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        int onehot;
        onehot = (m_owner == 1) ? 2 : 1;
        checkEq("gnt", 32'(gnt), (m_phase == 1) ? onehot : 0);
        checkEq("rsp_vld", 32'(rsp_vld), (m_phase == 2) ? onehot : 0);
        checkEq("rsp_sum", 32'(rsp_sum), 32'(m_sum));
        checkEq("rsp_err", 32'(rsp_err), m_err);
        checkEq("busy", 32'(busy), (m_phase != 0) ? 1 : 0);
        checkEq("ovf_cnt0", 32'(ovf_cnt0), m_cnt[0]);
        checkEq("ovf_cnt1", 32'(ovf_cnt1), m_cnt[1]);
    endtask

    // One clock per call: drive at the falling edge, predict, check at the next falling edge.
    task automatic applyStimulus(input logic rstn_v, input logic [1:0] req_v,
                                 input logic [15:0] a0_v, input logic [15:0] b0_v,
                                 input logic [15:0] a1_v, input logic [15:0] b1_v,
                                 input logic [1:0] rdy_v, input logic [1:0] clr_v);
        rst_n = rstn_v; req = req_v;
        a0 = a0_v; b0 = b0_v; a1 = a1_v; b1 = b1_v;
        rsp_rdy = rdy_v; cnt_clr = clr_v;
        modelStep();
        @(negedge clk);
        checkOutput();
    endtask

    task automatic doTxn(input logic [1:0] req_v, input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] clr_acc,
                         output logic [1:0] gnt_seen, output logic [1:0] vld_seen,
                         output logic [15:0] sum_seen, output logic err_seen);
        applyStimulus(1'b1, req_v, a, b, a, b, 2'b00, 2'b00);
        gnt_seen = gnt;
        applyStimulus(1'b1, 2'b00, a, b, a, b, 2'b00, 2'b00);
        vld_seen = rsp_vld; sum_seen = rsp_sum; err_seen = rsp_err;
        applyStimulus(1'b1, 2'b00, a, b, a, b, 2'b11, clr_acc);
    endtask

    logic [1:0]  g_s;
    logic [1:0]  v_s;
    logic [15:0] s_s;
    logic        e_s;
    logic [1:0]  pend;
    logic [15:0] ra [2];
    logic [15:0] rb [2];
    logic        rstn_r;

    initial begin
        applyStimulus(1'b0, 2'b00, '0, '0, '0, '0, 2'b00, 2'b00);
        applyStimulus(1'b0, 2'b00, '0, '0, '0, '0, 2'b00, 2'b00);
        checkEq("reset_busy", 32'(busy), 0);
        checkEq("reset_vld", 32'(rsp_vld), 0);

        applyStimulus(1'b1, 2'b01, 16'h1234, 16'h1111, '0, '0, 2'b00, 2'b00);
        checkEq("t1_gnt", 32'(gnt), 32'h1);
        applyStimulus(1'b1, 2'b00, 16'h1234, 16'h1111, '0, '0, 2'b00, 2'b00);
        checkEq("t1_vld", 32'(rsp_vld), 32'h1);
        checkEq("t1_sum", 32'(rsp_sum), 32'h2345);
        checkEq("t1_err", 32'(rsp_err), 0);
        applyStimulus(1'b1, 2'b00, 16'h1234, 16'h1111, '0, '0, 2'b01, 2'b00);
        checkEq("t1_cnt0", 32'(ovf_cnt0), 0);
        checkEq("t1_idle", 32'(busy), 0);

        doTxn(2'b10, 16'h7777, 16'h1111, 2'b00, g_s, v_s, s_s, e_s);
        checkEq("t2_gnt", 32'(g_s), 32'h2);
        checkEq("t2_sum", 32'(s_s), 32'h7777);
        checkEq("t2_err", 32'(e_s), 1);
        checkEq("t2_cnt1", 32'(ovf_cnt1), 1);
        doTxn(2'b10, 16'h8888, 16'h8888, 2'b00, g_s, v_s, s_s, e_s);
        checkEq("t2b_sum", 32'(s_s), 32'h8888);
        checkEq("t2b_cnt1", 32'(ovf_cnt1), 2);

        doTxn(2'b01, 16'h7F81, 16'h1F8F, 2'b00, g_s, v_s, s_s, e_s);
        checkEq("t3_sum", 32'(s_s), 32'h7E80);
        checkEq("t3_err", 32'(e_s), 1);

        applyStimulus(1'b1, 2'b01, 16'h0123, 16'h0456, 16'hFFFF, 16'hFFFF, 2'b00, 2'b00);
        applyStimulus(1'b1, 2'b00, 16'h0123, 16'h0456, 16'hFFFF, 16'hFFFF, 2'b00, 2'b00);
        for (int k = 0; k < 5; k++)
            applyStimulus(1'b1, 2'b10, 16'h0123, 16'h0456, 16'hFFFF, 16'hFFFF, 2'b10, 2'b00);
        checkEq("bp_vld", 32'(rsp_vld), 32'h1);
        checkEq("bp_sum", 32'(rsp_sum), 32'h0577);
        checkEq("bp_busy", 32'(busy), 1);
        applyStimulus(1'b1, 2'b10, 16'h0123, 16'h0456, 16'hFFFF, 16'hFFFF, 2'b01, 2'b00);
        checkEq("bp_idle", 32'(busy), 0);
        checkEq("bp_cnt0", 32'(ovf_cnt0), 2);

        applyStimulus(1'b0, 2'b00, '0, '0, '0, '0, 2'b00, 2'b00);
        for (int k = 0; k < 4; k++) begin
            doTxn(2'b11, 16'h1111, 16'h2222, 2'b00, g_s, v_s, s_s, e_s);
            checkEq("rr_gnt", 32'(g_s), (k % 2 == 0) ? 32'h1 : 32'h2);
            checkEq("rr_sum", 32'(s_s), 32'h3333);
        end

        applyStimulus(1'b0, 2'b00, '0, '0, '0, '0, 2'b00, 2'b00);
        for (int k = 0; k < 4; k++)
            doTxn(2'b01, 16'h7777, 16'h1111, 2'b00, g_s, v_s, s_s, e_s);
        checkEq("sat_cnt0", 32'(ovf_cnt0), 3);
        doTxn(2'b01, 16'h7777, 16'h1111, 2'b01, g_s, v_s, s_s, e_s);
        checkEq("clr_cnt0", 32'(ovf_cnt0), 0);

        applyStimulus(1'b1, 2'b01, 16'h7777, 16'h7777, '0, '0, 2'b00, 2'b00);
        applyStimulus(1'b0, 2'b01, 16'h7777, 16'h7777, '0, '0, 2'b00, 2'b00);
        checkEq("rst_gnt", 32'(gnt), 0);
        checkEq("rst_busy", 32'(busy), 0);
        checkEq("rst_sum", 32'(rsp_sum), 0);
        applyStimulus(1'b1, 2'b00, '0, '0, '0, '0, 2'b00, 2'b00);
        checkEq("rst_vld", 32'(rsp_vld), 0);

        pend = '0;
        ra[0] = '0; ra[1] = '0; rb[0] = '0; rb[1] = '0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            rstn_r = ($urandom % 250) != 0;
            for (int i = 0; i < 2; i++) begin
                if (!rstn_r) begin
                    pend[i] = 1'b0;
                end else begin
                    if (m_phase == 1 && m_owner == i && pend[i])
                        pend[i] = 1'($urandom % 2);
                    if (!pend[i] && ($urandom % 3) == 0) begin
                        pend[i] = 1'b1;
                        ra[i] = 16'($urandom);
                        rb[i] = 16'($urandom);
                    end
                end
            end
            applyStimulus(rstn_r, pend, ra[0], rb[0], ra[1], rb[1],
                          {1'(($urandom % 3) != 0), 1'(($urandom % 3) != 0)},
                          {1'(($urandom % 20) == 0), 1'(($urandom % 20) == 0)});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
